// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor/encoder emulator.
// Drive-mode enumeration, mode decode and default widths.
package motor_pkg;

  localparam int DEF_PERIOD_W = 14;
  localparam int DEF_PULSE_W  = 64;

  typedef enum logic [2:0] {
    STANDBY = 3'd0,
    BRAKE   = 3'd1,
    FWD     = 3'd2,
    REV     = 3'd3,
    COAST   = 3'd4
  } drv_mode_t;

  // Driver truth table: STBY low overrides, otherwise IN1/IN2 pick the mode.
  function automatic drv_mode_t decode_mode(input logic stnby, input logic in1, input logic in2);
    drv_mode_t m;
    if (!stnby) begin
      m = STANDBY;
    end else begin
      case ({in1, in2})
        2'b11:   m = BRAKE;
        2'b10:   m = FWD;
        2'b01:   m = REV;
        default: m = COAST;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/motor_fb_emu_if.sv
// Motor-driver PMOD side (pwm/in1/in2/stnby) and feedback side of the emulator.
// Optional pulse_cnt member is present when MOTOR_FB_EMU_PCNT_EN is defined.
interface motor_fb_emu_if #(
  parameter int PERIOD_W = motor_pkg::DEF_PERIOD_W
);
  logic                pwm;
  logic                in1;
  logic                in2;
  logic                stnby;
  logic                fb;
  logic                fb_dir;
  logic [PERIOD_W-1:0] duty;
  logic                duty_vld;
  logic [PERIOD_W:0]   speed;
  logic                drop;
`ifdef MOTOR_FB_EMU_PCNT_EN
  logic [15:0]         pulse_cnt;
`endif

  // Driver side: produces the drive signals, observes the feedback.
  modport master (
    output pwm, output in1, output in2, output stnby,
    input fb, input fb_dir, input duty, input duty_vld, input speed, input drop
`ifdef MOTOR_FB_EMU_PCNT_EN
    , input pulse_cnt
`endif
  );

  // Emulator side.
  modport slave (
    input pwm, input in1, input in2, input stnby,
    output fb, output fb_dir, output duty, output duty_vld, output speed, output drop
`ifdef MOTOR_FB_EMU_PCNT_EN
    , output pulse_cnt
`endif
  );
endinterface

// File: rtl/fb_pulse_nco.sv
// Feedback pulse generator: phase accumulator whose carry launches a
// fixed-width pulse. Carries during a pulse are lost and flagged in drop_o.
// pulse_cnt_o exists only when MOTOR_FB_EMU_PCNT_EN is defined.
module fb_pulse_nco #(
  parameter int NCO_W   = 24,
  parameter int PULSE_W = 64,
  parameter int INC_W   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_i,
  output logic             fb_o,
  output logic             drop_o
`ifdef MOTOR_FB_EMU_PCNT_EN
  , output logic [15:0]    pulse_cnt_o
`endif
);
  localparam int CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_W - 1);

  logic [NCO_W-1:0] phase_q;
  logic [NCO_W:0]   inc_ext_s;
  logic [NCO_W:0]   phase_sum_s;
  logic             carry_s;
  logic             fb_q;
  logic             drop_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef MOTOR_FB_EMU_PCNT_EN
  logic [15:0]      pcnt_q;
`endif

  // Accumulate |speed|; the bit above the phase is the carry.
  always_comb begin
    inc_ext_s              = '0;
    inc_ext_s[INC_W-1:0]   = inc_i;
    phase_sum_s            = {1'b0, phase_q} + inc_ext_s;
    carry_s                = phase_sum_s[NCO_W];
  end

  // Phase register, pulse stretcher and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      fb_q    <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
`ifdef MOTOR_FB_EMU_PCNT_EN
      pcnt_q  <= 16'd0;
`endif
    end else begin
      phase_q <= phase_sum_s[NCO_W-1:0];
      if (fb_q) begin
        // A pulse is in flight: never extend it, just record the lost carry.
        if (carry_s) begin
          drop_q <= 1'b1;
        end
        if (cnt_q == '0) begin
          fb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else if (carry_s) begin
        fb_q   <= 1'b1;
        cnt_q  <= CNT_LAST;
`ifdef MOTOR_FB_EMU_PCNT_EN
        pcnt_q <= pcnt_q + 16'd1;
`endif
      end
    end
  end

  assign fb_o   = fb_q;
  assign drop_o = drop_q;
`ifdef MOTOR_FB_EMU_PCNT_EN
  assign pulse_cnt_o = pcnt_q;
`endif

endmodule

// File: rtl/motor_fb_emu.sv
// Single-channel motor + encoder emulator for hardware-in-loop builds.
// Measures PWM duty per 2^PERIOD_W-cycle window, decodes drive mode,
// models speed as a first-order lag and emits speed-proportional pulses.
// Optional feature macro: MOTOR_FB_EMU_PCNT_EN (adds pulse_cnt).
module motor_fb_emu
  import motor_pkg::*;
#(
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int LAG_SHIFT = 4,
  parameter int NCO_W     = 24,
  parameter int PULSE_W   = DEF_PULSE_W
) (
  input logic           clk,
  input logic           rst,
  motor_fb_emu_if.slave bus
);
  localparam logic [PERIOD_W-1:0]        WMAX   = {PERIOD_W{1'b1}};
  localparam logic signed [PERIOD_W+1:0] SAT_HI = $signed({2'b00, WMAX});
  localparam logic signed [PERIOD_W+1:0] SAT_LO = -SAT_HI;
  localparam logic signed [PERIOD_W:0]   SPD_HI = $signed({1'b0, WMAX});
  localparam logic signed [PERIOD_W:0]   SPD_LO = -SPD_HI;
  localparam logic signed [PERIOD_W+1:0] POS1   = {{(PERIOD_W+1){1'b0}}, 1'b1};
  localparam logic signed [PERIOD_W+1:0] NEG1   = {(PERIOD_W+2){1'b1}};

  // Synchronizer stages, bit order {stnby, in1, in2, pwm}.
  logic [3:0]                  sync1_q, sync2_q;
  logic [PERIOD_W-1:0]         wcnt_q;
  logic [PERIOD_W:0]           hcnt_q, hcnt_inc_s;
  logic [PERIOD_W-1:0]         duty_q, duty_sat_s;
  logic                        duty_vld_q;
  logic signed [PERIOD_W:0]    target_q, target_s;
  logic                        brake_q;
  logic signed [PERIOD_W:0]    speed_q, speed_d;
  logic                        fb_dir_q;
  logic signed [PERIOD_W+1:0]  diff_s, step_raw_s, step_s, sum_s;
  logic [PERIOD_W:0]           speed_abs_s;
  logic                        window_end_s;
  drv_mode_t                   mode_s;

  // Window-end bookkeeping: current-cycle high count, clamp and target.
  always_comb begin
    window_end_s = (wcnt_q == WMAX);
    hcnt_inc_s   = hcnt_q + {{PERIOD_W{1'b0}}, sync2_q[0]};
    if (hcnt_inc_s > {1'b0, WMAX}) begin
      duty_sat_s = WMAX;
    end else begin
      duty_sat_s = hcnt_inc_s[PERIOD_W-1:0];
    end
    mode_s = decode_mode(sync2_q[3], sync2_q[2], sync2_q[1]);
    case (mode_s)
      FWD:     target_s = $signed({1'b0, duty_sat_s});
      REV:     target_s = -$signed({1'b0, duty_sat_s});
      default: target_s = '0;
    endcase
  end

  // Lag filter: step toward target, forcing at least one LSB so it lands exactly.
  always_comb begin
    diff_s     = $signed({target_q[PERIOD_W], target_q}) - $signed({speed_q[PERIOD_W], speed_q});
    step_raw_s = diff_s >>> LAG_SHIFT;
    if ((step_raw_s == '0) && (diff_s != '0)) begin
      step_s = diff_s[PERIOD_W+1] ? NEG1 : POS1;
    end else begin
      step_s = step_raw_s;
    end
    sum_s = $signed({speed_q[PERIOD_W], speed_q}) + step_s;
    if (!duty_vld_q) begin
      speed_d = speed_q;
    end else if (brake_q) begin
      speed_d = '0;
    end else if (sum_s > SAT_HI) begin
      speed_d = SPD_HI;
    end else if (sum_s < SAT_LO) begin
      speed_d = SPD_LO;
    end else begin
      speed_d = sum_s[PERIOD_W:0];
    end
    speed_abs_s = speed_q[PERIOD_W] ? -speed_q : speed_q;
  end

  // Input synchronizers, window/high counters, duty capture and speed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
      wcnt_q     <= '0;
      hcnt_q     <= '0;
      duty_q     <= '0;
      duty_vld_q <= 1'b0;
      target_q   <= '0;
      brake_q    <= 1'b0;
      speed_q    <= '0;
      fb_dir_q   <= 1'b0;
    end else begin
      sync1_q <= {bus.stnby, bus.in1, bus.in2, bus.pwm};
      sync2_q <= sync1_q;
      wcnt_q  <= wcnt_q + 1'b1;
      if (window_end_s) begin
        hcnt_q     <= '0;
        duty_q     <= duty_sat_s;
        duty_vld_q <= 1'b1;
        target_q   <= target_s;
        brake_q    <= (mode_s == BRAKE);
      end else begin
        hcnt_q     <= hcnt_inc_s;
        duty_vld_q <= 1'b0;
      end
      speed_q  <= speed_d;
      fb_dir_q <= speed_d[PERIOD_W];
    end
  end

  fb_pulse_nco #(
    .NCO_W   (NCO_W),
    .PULSE_W (PULSE_W),
    .INC_W   (PERIOD_W + 1)
  ) u_nco (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (speed_abs_s),
    .fb_o   (bus.fb),
    .drop_o (bus.drop)
`ifdef MOTOR_FB_EMU_PCNT_EN
    , .pulse_cnt_o (bus.pulse_cnt)
`endif
  );

  assign bus.duty     = duty_q;
  assign bus.duty_vld = duty_vld_q;
  assign bus.speed    = speed_q;
  assign bus.fb_dir   = fb_dir_q;

endmodule

// File: tb/tb_motor_fb_emu.sv
// Randomized bench for motor_fb_emu with a cycle-level behavioural model.
// Uses a reduced configuration (256-cycle windows) so many windows fit in the run.
module tb_motor_fb_emu;
  localparam int P    = 8;
  localparam int L    = 2;
  localparam int N    = 12;
  localparam int PW   = 24;
  localparam int WIN  = 1 << P;
  localparam int WMAX = WIN - 1;
  localparam int NMOD = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motor_fb_emu_if #(.PERIOD_W(P)) bus();

  motor_fb_emu #(
    .PERIOD_W  (P),
    .LAG_SHIFT (L),
    .NCO_W     (N),
    .PULSE_W   (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] dl0, dl1;                  // 2-stage input delay, {stnby,in1,in2,pwm}
  int m_w, m_hc, m_duty, m_target, m_speed, m_phase, m_rem, m_pcnt;
  bit m_vld, m_brake, m_fbdir, m_drop;

  function automatic int lag(input int tgt, input int spd);
    int d, k, q, r;
    d = tgt - spd;
    k = 1 << L;
    q = (d >= 0) ? d / k : -((-d + k - 1) / k);   // floor division
    if (q == 0 && d != 0) q = (d > 0) ? 1 : -1;
    r = spd + q;
    if (r > WMAX) r = WMAX;
    if (r < -WMAX) r = -WMAX;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dl0 = '0; dl1 = '0;
      m_w = 0; m_hc = 0; m_duty = 0; m_target = 0; m_speed = 0;
      m_phase = 0; m_rem = 0; m_pcnt = 0;
      m_vld = 0; m_brake = 0; m_fbdir = 0; m_drop = 0;
    end else begin
      int sum, hc_now, absv;
      bit carry, s_stb, s_in1, s_in2, s_pwm;
      {s_stb, s_in1, s_in2, s_pwm} = dl1;
      // feedback pulses follow the speed held before this edge
      absv    = (m_speed < 0) ? -m_speed : m_speed;
      sum     = m_phase + absv;
      carry   = (sum >= NMOD);
      m_phase = sum % NMOD;
      if (m_rem > 0) begin
        if (carry) m_drop = 1;
        m_rem--;
      end else if (carry) begin
        m_rem  = PW;
        m_pcnt = (m_pcnt + 1) % 65536;
      end
      // speed moves one cycle after a duty strobe
      if (m_vld) m_speed = m_brake ? 0 : lag(m_target, m_speed);
      m_fbdir = (m_speed < 0);
      // window measurement
      hc_now = m_hc + s_pwm;
      if (m_w == WMAX) begin
        m_duty   = (hc_now > WMAX) ? WMAX : hc_now;
        m_vld    = 1;
        m_brake  = s_stb && s_in1 && s_in2;
        if (s_stb && s_in1 && !s_in2)      m_target = m_duty;
        else if (s_stb && !s_in1 && s_in2) m_target = -m_duty;
        else                               m_target = 0;
        m_hc = 0;
      end else begin
        m_hc  = hc_now;
        m_vld = 0;
      end
      m_w = (m_w + 1) % WIN;
      dl1 = dl0;
      dl0 = {bus.stnby, bus.in1, bus.in2, bus.pwm};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("fb",       int'(bus.fb),       (m_rem > 0) ? 1 : 0);
      check("fb_dir",   int'(bus.fb_dir),   int'(m_fbdir));
      check("duty",     int'(bus.duty),     m_duty);
      check("duty_vld", int'(bus.duty_vld), int'(m_vld));
      check("speed",    int'($signed(bus.speed)), m_speed);
      check("drop",     int'(bus.drop),     int'(m_drop));
`ifdef MOTOR_FB_EMU_PCNT_EN
      check("pulse_cnt", int'(bus.pulse_cnt), m_pcnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_mode(input bit s, input bit a, input bit b);
    bus.stnby = s; bus.in1 = a; bus.in2 = b;
  endtask

  // Runs nwin windows; duty_hi highs per 256 cycles (periodic or random per cycle).
  task automatic run_windows(input int nwin, input int duty_hi, input bit randpwm, input bit jitter);
    for (int c = 0; c < nwin * WIN; c++) begin
      @(negedge clk);
      if (randpwm) bus.pwm = ($urandom_range(0, WIN - 1) < duty_hi);
      else         bus.pwm = ((c % WIN) < duty_hi);
      if (jitter && ($urandom_range(0, 63) == 0)) bus.in2 = ~bus.in2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb"},       int'(bus.fb),       0);
    check({tag, "_fb_dir"},   int'(bus.fb_dir),   0);
    check({tag, "_duty"},     int'(bus.duty),     0);
    check({tag, "_duty_vld"}, int'(bus.duty_vld), 0);
    check({tag, "_speed"},    int'($signed(bus.speed)), 0);
    check({tag, "_drop"},     int'(bus.drop),     0);
`ifdef MOTOR_FB_EMU_PCNT_EN
    check({tag, "_pulse_cnt"}, int'(bus.pulse_cnt), 0);
`endif
  endtask

  initial begin
    bit seen;
    bus.pwm = 1'b0;
    set_mode(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_all_zero("reset");
    rst = 1'b0;

    // 25% PWM forward: every window holds exactly 64 highs
    set_mode(1'b1, 1'b1, 1'b0);
    run_windows(30, 64, 1'b0, 1'b0);
    check_range("duty25", int'(bus.duty), 63, 65);
    check("speed25", int'($signed(bus.speed)), 64);
    check("drop25", int'(bus.drop), 0);

    // full PWM forward: saturated duty, pulses now arrive faster than PW
    run_windows(30, WIN, 1'b0, 1'b0);
    check("duty_full", int'(bus.duty), WMAX);
    check("speed_full", int'($signed(bus.speed)), WMAX);
    check("drop_full", int'(bus.drop), 1);

    // brake: speed zero after the next window end, pulses stop
    set_mode(1'b1, 1'b1, 1'b1);
    run_windows(2, WIN, 1'b0, 1'b0);
    check("speed_brake", int'($signed(bus.speed)), 0);
    check("fb_brake", int'(bus.fb), 0);

    // reverse at 50%
    set_mode(1'b1, 1'b0, 1'b1);
    run_windows(30, WIN / 2, 1'b0, 1'b0);
    check("speed_rev", int'($signed(bus.speed)), -(WIN / 2));
    check("fb_dir_rev", int'(bus.fb_dir), 1);

    // standby: decays to exactly zero
    set_mode(1'b0, 1'b0, 1'b1);
    run_windows(40, WIN / 2, 1'b0, 1'b0);
    check("speed_stby", int'($signed(bus.speed)), 0);
    check("fb_dir_stby", int'(bus.fb_dir), 0);
    check("fb_stby", int'(bus.fb), 0);

    // random modes, duties and mid-window input changes
    for (int s = 0; s < 16; s++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (s == 7) begin
        repeat ($urandom_range(1, 300)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      run_windows($urandom_range(2, 5), $urandom_range(0, WIN), 1'b1, 1'b1);
    end

    // reset while a pulse is high
    set_mode(1'b1, 1'b1, 1'b0);
    run_windows(8, WIN, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.fb;
    end
    check("fb_wait", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_pulse");
    run_windows(1, WIN, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
